// File: rtl/sgdmac_pkg.sv
// rtl/sgdmac_pkg.sv - shared types and constants for the scatter-gather DMA engines
package sgdmac_pkg;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_WAIT_DATA,
        WR_AW_REQ,
        WR_W_DATA,
        WR_B_WAIT
    } wr_state_e;

    localparam logic [2:0] AXSIZE_4B       = 3'b010;
    localparam logic [1:0] AXBURST_INCR    = 2'b01;
    localparam logic [1:0] BRESP_OKAY      = 2'b00;
    localparam int         MAX_BURST_BYTES = 64;

    localparam int CMD_ADDR_MSB = 47;
    localparam int CMD_ADDR_LSB = 16;
    localparam int CMD_CNT_MSB  = 15;
    localparam int CMD_WORD_LSB = 2;

    // AXI length field (beats - 1) for the next burst of a transfer.
    function automatic logic [3:0] burst_len_f(input logic [15:0] remain_bytes);
        if (remain_bytes >= 16'(MAX_BURST_BYTES)) begin
            return 4'hF;
        end
        return remain_bytes[5:2] - 4'd1;
    endfunction

endpackage

// File: rtl/sgdmac_write_if.sv
// rtl/sgdmac_write_if.sv - AXI write-channel bundle between the write engine and memory
interface sgdmac_write_if;

    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sgdmac_write.sv
// rtl/sgdmac_write.sv - drains the data FIFO into AXI INCR write bursts of up to 16 beats
module sgdmac_write
    import sgdmac_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [47:0]                   cmd_i,
    output logic                          done_o,
    output logic                          err_o,
    input  logic                          fifo_empty_i,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_i,
    input  logic [31:0]                   fifo_rdata_i,
    output logic                          fifo_rden_o,
    sgdmac_write_if.master                axi
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_e   state_q;
    logic [31:0] dst_addr_q;
    logic [15:0] remain_q;
    logic [3:0]  beat_cnt_q;
    logic [3:0]  beat_last_q;
    logic        err_q;

    logic [3:0]       burst_len_d;
    logic [CNT_W-1:0] need_words_d;
    logic [15:0]      remain_d;
    logic [13:0]      cmd_words;
    logic             w_hs;
    logic             unused_cmd_bits;

    assign cmd_words       = cmd_i[CMD_CNT_MSB:CMD_WORD_LSB];
    assign unused_cmd_bits = ^cmd_i[CMD_WORD_LSB-1:0];

    // AW is held back until the whole burst is buffered so W never starves.
    assign burst_len_d  = burst_len_f(remain_q);
    assign need_words_d = CNT_W'(burst_len_d) + CNT_W'(1);
    assign remain_d     = (remain_q >= 16'(MAX_BURST_BYTES)) ?
                          remain_q - 16'(MAX_BURST_BYTES) : 16'h0000;

    assign axi.awvalid = (state_q == WR_AW_REQ);
    assign axi.awaddr  = dst_addr_q;
    assign axi.awlen   = (state_q == WR_AW_REQ) ? burst_len_d : 4'h0;
    assign axi.awsize  = AXSIZE_4B;
    assign axi.awburst = AXBURST_INCR;

    assign axi.wvalid  = (state_q == WR_W_DATA) && !fifo_empty_i;
    assign axi.wdata   = fifo_rdata_i;
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = (state_q == WR_W_DATA) && (beat_cnt_q == beat_last_q);
    assign axi.bready  = (state_q == WR_B_WAIT);

    assign w_hs        = axi.wvalid && axi.wready;
    assign fifo_rden_o = w_hs;
    assign done_o      = (state_q == WR_IDLE);
    assign err_o       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WR_IDLE;
            dst_addr_q  <= '0;
            remain_q    <= '0;
            beat_cnt_q  <= '0;
            beat_last_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (start_i && (cmd_words != 14'd0)) begin
                        dst_addr_q <= cmd_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        remain_q   <= {cmd_words, 2'b00};
                        err_q      <= 1'b0;
                        state_q    <= WR_WAIT_DATA;
                    end
                end
                WR_WAIT_DATA: begin
                    if (fifo_cnt_i >= need_words_d) begin
                        state_q <= WR_AW_REQ;
                    end
                end
                WR_AW_REQ: begin
                    if (axi.awready) begin
                        beat_last_q <= burst_len_d;
                        beat_cnt_q  <= 4'd0;
                        dst_addr_q  <= dst_addr_q + 32'(MAX_BURST_BYTES);
                        remain_q    <= remain_d;
                        state_q     <= WR_W_DATA;
                    end
                end
                WR_W_DATA: begin
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                        if (axi.wlast) begin
                            state_q <= WR_B_WAIT;
                        end
                    end
                end
                WR_B_WAIT: begin
                    if (axi.bvalid) begin
                        err_q   <= err_q | (axi.bresp != BRESP_OKAY);
                        state_q <= (remain_q == 16'h0000) ? WR_IDLE : WR_WAIT_DATA;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sgdmac_write.sv
// tb/tb_sgdmac_write.sv - self-checking bench for the scatter-gather DMA write engine
module tb_sgdmac_write;

    localparam int FIFO_DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [47:0] cmd_i = '0;
    logic        done_o;
    logic        err_o;
    logic        fifo_empty_i = 1'b1;
    logic [6:0]  fifo_cnt_i = '0;
    logic [31:0] fifo_rdata_i = '0;
    logic        fifo_rden_o;

    sgdmac_write_if axi_if ();

    sgdmac_write #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .cmd_i        (cmd_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .fifo_empty_i (fifo_empty_i),
        .fifo_cnt_i   (fifo_cnt_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rden_o  (fifo_rden_o),
        .axi          (axi_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Registered FWFT FIFO model fed from a source queue at a programmable rate.
    logic [31:0] fifo_q[$];
    logic [31:0] src_q[$];
    int feed_period = 1;
    int feed_ctr = 0;
    bit fifo_flush = 0;
    bit pop_seen = 0;

    always @(posedge clk) begin
        cyc++;
        if (pop_seen) begin
            if (fifo_q.size() == 0) check("fifo_underflow", 1, 0);
            else void'(fifo_q.pop_front());
        end
        if (fifo_flush) begin
            fifo_q.delete();
            src_q.delete();
        end else if (src_q.size() > 0 && fifo_q.size() < FIFO_DEPTH) begin
            feed_ctr++;
            if (feed_ctr >= feed_period) begin
                feed_ctr = 0;
                fifo_q.push_back(src_q.pop_front());
            end
        end
        fifo_cnt_i   <= 7'(fifo_q.size());
        fifo_empty_i <= (fifo_q.size() == 0);
        fifo_rdata_i <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    end

    logic [31:0] aw_addr_seen[$];
    logic [3:0]  aw_len_seen[$];
    logic [31:0] w_data_seen[$];
    bit          w_last_seen[$];
    int first_aw_cyc = -1;
    int first_w_cyc = -1;
    int last_w_cyc = -1;
    int b_owed = 0;
    bit b_taken = 0;
    bit rnd_ready = 0;
    int err_burst = -1;
    int b_index = 0;
    bit aw_stall = 0;
    bit w_stall = 0;
    logic [35:0] aw_hold = '0;
    logic [32:0] w_hold = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pop_seen = 0;
            b_taken  = 0;
            aw_stall = 0;
            w_stall  = 0;
        end else begin
            pop_seen = fifo_rden_o;
            b_taken  = axi_if.bvalid && axi_if.bready;
            if (fifo_rden_o || axi_if.wvalid)
                check("pop_iff_w_handshake", fifo_rden_o, axi_if.wvalid && axi_if.wready);
            if (axi_if.awvalid) begin
                if (first_aw_cyc < 0) first_aw_cyc = cyc;
                if (fifo_cnt_i < 7'(axi_if.awlen) + 7'd1)
                    check("aw_before_burst_buffered", fifo_cnt_i, 7'(axi_if.awlen) + 7'd1);
                if (b_owed != 0 || axi_if.bvalid) check("aw_with_b_outstanding", 1, 0);
                if (aw_stall) check("aw_stable", {axi_if.awaddr, axi_if.awlen}, aw_hold);
            end else if (aw_stall) begin
                check("aw_valid_held", 0, 1);
            end
            if (axi_if.awvalid && axi_if.awready) begin
                aw_addr_seen.push_back(axi_if.awaddr);
                aw_len_seen.push_back(axi_if.awlen);
                check("awsize_awburst", {axi_if.awsize, axi_if.awburst}, {3'b010, 2'b01});
            end
            aw_stall = axi_if.awvalid && !axi_if.awready;
            aw_hold  = {axi_if.awaddr, axi_if.awlen};
            if (w_stall)
                check("w_stable", {axi_if.wvalid, axi_if.wdata, axi_if.wlast}, {1'b1, w_hold});
            if (axi_if.wvalid && axi_if.wready) begin
                w_data_seen.push_back(axi_if.wdata);
                w_last_seen.push_back(axi_if.wlast);
                if (axi_if.wstrb != 4'hF) check("wstrb", axi_if.wstrb, 4'hF);
                if (first_w_cyc < 0) first_w_cyc = cyc;
                last_w_cyc = cyc;
                if (axi_if.wlast) b_owed++;
            end
            w_stall = axi_if.wvalid && !axi_if.wready;
            w_hold  = {axi_if.wdata, axi_if.wlast};
        end
    end

    // Memory-side responder: random ready stalls and one B per completed burst.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            axi_if.awready = 1'b0;
            axi_if.wready  = 1'b0;
            axi_if.bvalid  = 1'b0;
            axi_if.bresp   = 2'b00;
            b_owed = 0;
        end else begin
            if (rnd_ready) begin
                axi_if.awready = 1'($urandom_range(0, 1));
                axi_if.wready  = ($urandom_range(0, 2) != 0);
            end else begin
                axi_if.awready = 1'b1;
                axi_if.wready  = 1'b1;
            end
            if (axi_if.bvalid && b_taken) begin
                axi_if.bvalid = 1'b0;
                b_taken = 0;
            end else if (!axi_if.bvalid && b_owed > 0 && (!rnd_ready || $urandom_range(0, 2) == 0)) begin
                axi_if.bvalid = 1'b1;
                axi_if.bresp  = (b_index == err_burst) ? 2'b10 : 2'b00;
                b_index++;
                b_owed--;
            end
        end
    end

    task automatic run_cmd(input string tag, input logic [31:0] addr, input int bytes,
                           input int period, input bit prefill, input bit rnd,
                           input int errb, input int exp_bursts, input bit exp_err);
        logic [31:0] exp_data[$];
        logic [31:0] exp_addr[$];
        logic [3:0]  exp_len[$];
        bit          exp_last[$];
        logic [31:0] d;
        int words, rem, n, k, start_cyc, waited;
        bit ok;
        words = (bytes & 32'hFFFF) >> 2;
        for (int i = 0; i < words; i++) begin
            d = $urandom;
            src_q.push_back(d);
            exp_data.push_back(d);
        end
        rem = words;
        k = 0;
        while (rem > 0) begin
            n = (rem > 16) ? 16 : rem;
            exp_addr.push_back(addr + 32'(64 * k));
            exp_len.push_back(4'(n - 1));
            for (int j = 0; j < n; j++) exp_last.push_back(j == n - 1);
            rem -= n;
            k++;
        end
        feed_period = period;
        rnd_ready = rnd;
        err_burst = errb;
        b_index = 0;
        aw_addr_seen.delete();
        aw_len_seen.delete();
        w_data_seen.delete();
        w_last_seen.delete();
        first_aw_cyc = -1;
        first_w_cyc = -1;
        last_w_cyc = -1;
        if (prefill) begin
            waited = 0;
            while (fifo_q.size() < words && waited < 200) begin
                @(posedge clk);
                waited++;
            end
        end
        @(posedge clk);
        #1;
        start_i = 1'b1;
        cmd_i = {addr, 16'(bytes)};
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check({tag, "_done_fell"}, done_o, 0);
        check({tag, "_err_cleared"}, err_o, 0);
        waited = 0;
        while (!done_o && waited < 6000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, "_completed"}, done_o, 1);
        check({tag, "_aw_count"}, aw_addr_seen.size(), exp_bursts);
        for (int i = 0; i < aw_addr_seen.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s_aw%0d_addr", tag, i), aw_addr_seen[i], exp_addr[i]);
            check($sformatf("%s_aw%0d_len", tag, i), aw_len_seen[i], exp_len[i]);
        end
        check({tag, "_beats"}, w_data_seen.size(), words);
        ok = (w_data_seen.size() == words);
        for (int i = 0; ok && i < words; i++)
            if (w_data_seen[i] !== exp_data[i] || w_last_seen[i] !== exp_last[i]) ok = 0;
        check({tag, "_data_order_wlast"}, ok, 1);
        check({tag, "_fifo_drained"}, fifo_q.size() + src_q.size(), 0);
        check({tag, "_err"}, err_o, exp_err);
        check({tag, "_start_to_aw_ge2"}, (first_aw_cyc - start_cyc) >= 2, 1);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          bytes;
        int          period;
        bit          prefill;
        bit          rnd;
        int          errb;
        int          exp_bursts;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int waited;
        logic [31:0] r;
        int words, errb;

        vecs[0] = '{32'h1000_0000,  64, 1, 1, 0, -1, 1, 0};
        vecs[1] = '{32'h2000_0000, 200, 1, 1, 0, -1, 4, 0};
        vecs[2] = '{32'h3000_0000, 128, 3, 0, 0, -1, 2, 0};
        vecs[3] = '{32'h5000_0000, 256, 1, 0, 1, -1, 4, 0};
        vecs[4] = '{32'h6000_0000, 200, 1, 0, 1,  1, 4, 1};
        vecs[5] = '{32'hFFFF_FFC0, 128, 2, 0, 1, -1, 2, 0};
        vecs[6] = '{32'h7000_0000,   4, 1, 0, 0, -1, 1, 0};
        vecs[7] = '{32'h7000_1000,  67, 1, 1, 1, -1, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", axi_if.awvalid, 0);
        check("rst_wvalid", axi_if.wvalid, 0);
        check("rst_wlast", axi_if.wlast, 0);
        check("rst_bready", axi_if.bready, 0);
        check("rst_rden", fifo_rden_o, 0);
        check("rst_err", err_o, 0);
        check("rst_done", done_o, 1);
        check("rst_awaddr_awlen", {axi_if.awaddr, axi_if.awlen}, 36'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("v%0d", i), vecs[i].addr, vecs[i].bytes, vecs[i].period,
                    vecs[i].prefill, vecs[i].rnd, vecs[i].errb, vecs[i].exp_bursts, vecs[i].exp_err);
            if (i == 0) check("v0_16_beats_in_16_cycles", last_w_cyc - first_w_cyc, 15);
            if (i == 4) begin
                repeat (4) @(posedge clk);
                #1;
                check("err_sticky_after_done", err_o, 1);
                start_i = 1'b1;
                cmd_i = {32'h9000_0000, 16'd3};
                @(posedge clk);
                #1;
                start_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("zero_word_start_done", done_o, 1);
                check("zero_word_start_err_kept", err_o, 1);
                check("zero_word_start_no_aw", axi_if.awvalid, 0);
            end
        end

        for (int t = 0; t < 6; t++) begin
            words = $urandom_range(1, 80);
            r = $urandom;
            errb = ($urandom_range(0, 1) != 0) ? $urandom_range(0, (words + 15) / 16 - 1) : -1;
            run_cmd($sformatf("rnd%0d", t), {r[31:6], 6'b0}, words * 4 + $urandom_range(0, 3),
                    $urandom_range(1, 3), 0, 1, errb, (words + 15) / 16, errb >= 0);
        end

        rnd_ready = 0;
        err_burst = -1;
        for (int i = 0; i < 16; i++) src_q.push_back($urandom);
        repeat (20) @(posedge clk);
        w_data_seen.delete();
        #1;
        start_i = 1'b1;
        cmd_i = {32'hA000_0000, 16'd64};
        @(posedge clk);
        #1;
        start_i = 1'b0;
        waited = 0;
        while (w_data_seen.size() < 6 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reset_reached_beat7", w_data_seen.size(), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_awvalid", axi_if.awvalid, 0);
        check("midrst_wvalid", axi_if.wvalid, 0);
        check("midrst_wlast", axi_if.wlast, 0);
        check("midrst_bready", axi_if.bready, 0);
        check("midrst_rden", fifo_rden_o, 0);
        check("midrst_done", done_o, 1);
        fifo_flush = 1;
        repeat (2) @(posedge clk);
        fifo_flush = 0;
        #1;
        rst_n = 1'b1;
        run_cmd("post_reset", 32'hB000_0000, 96, 1, 0, 1, -1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
